// File: rtl/core_ctrl_pkg.sv
// Shared types and helpers for the core run controller: FSM states, run result codes,
// and the constant helpers used to size the sequencing counters.
package core_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        CLK_ON,
        FETCH,
        RUN,
        DRAIN,
        STOP,
        DONE
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ST_NONE    = 2'd0,
        ST_HALT    = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_ABORT   = 2'd3
    } run_status_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Run-control bus between the host/core environment (master) and core_run_ctrl (slave):
// run request and result on one side, CoreTop reset/clock-gate/fetch launch on the other.
interface core_run_ctrl_if #(
    parameter int ADDR_W = core_ctrl_pkg::MEM_ADDR_WIDTH
);
    import core_ctrl_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] boot_addr;
    logic              abort;
    logic              core_heartbeat;
    logic              core_halt;
    logic              core_rstn;
    logic              cg_clk_en;
    logic [ADDR_W-1:0] first_fetch_addr;
    logic              first_fetch_trigger;
    logic              busy;
    logic              done;
    run_status_t       status;
    logic [31:0]       run_cycles;

    modport master (
        output start, boot_addr, abort, core_heartbeat, core_halt,
        input  core_rstn, cg_clk_en, first_fetch_addr, first_fetch_trigger,
        input  busy, done, status, run_cycles
    );

    modport slave (
        input  start, boot_addr, abort, core_heartbeat, core_halt,
        output core_rstn, cg_clk_en, first_fetch_addr, first_fetch_trigger,
        output busy, done, status, run_cycles
    );

endinterface

// File: rtl/core_watchdog.sv
// Heartbeat timer: counts enabled cycles since the last kick and flags expiry on the
// cycle the count would reach WDOG_CYCLES-1. Disabling it clears the count.
module core_watchdog #(
    parameter int WDOG_CYCLES = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic kick,
    output logic expired
);

    localparam int W = $clog2(WDOG_CYCLES);
    localparam logic [W-1:0] LAST = W'(WDOG_CYCLES - 1);
    localparam logic [W-1:0] PRE  = W'(WDOG_CYCLES - 2);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || kick) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Flag one cycle early so the FSM leaves RUN on the edge the limit is reached.
    assign expired = en && !kick && (cnt == PRE);

endmodule

// File: rtl/core_run_ctrl.sv
// Boot/run sequencer for CoreTop: reset, clock-gate enable, first-fetch launch, then
// supervises the run and stops the core on halt, watchdog timeout or abort.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_WIDTH,
    parameter int RST_CYCLES   = 10,
    parameter int CG_SETTLE    = 2,
    parameter int WDOG_CYCLES  = 25,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    core_run_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(max3(RST_CYCLES, CG_SETTLE, DRAIN_CYCLES) + 1);
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(CG_SETTLE - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);

    ctrl_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wd_en;
    logic              wd_expired;
    logic              abort_hit;

    assign wd_en     = (state == RUN);
    assign abort_hit = bus.abort && (state inside {CORE_RST, CLK_ON, FETCH, RUN, DRAIN});
    assign bus.first_fetch_addr = addr_q;

    core_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .en      (wd_en),
        .kick    (bus.core_heartbeat),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= IDLE;
            cnt                     <= '0;
            addr_q                  <= '0;
            bus.core_rstn           <= 1'b0;
            bus.cg_clk_en           <= 1'b0;
            bus.first_fetch_trigger <= 1'b0;
            bus.busy                <= 1'b0;
            bus.done                <= 1'b0;
            bus.status              <= ST_NONE;
            bus.run_cycles          <= '0;
        end else begin
            bus.first_fetch_trigger <= 1'b0;
            if (state == RUN || state == DRAIN) begin
                bus.run_cycles <= sat_inc32(bus.run_cycles);
            end

            if (abort_hit) begin
                // core_rstn is left alone so a stopped core stays inspectable.
                state         <= STOP;
                bus.cg_clk_en <= 1'b0;
                bus.status    <= ST_ABORT;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            state          <= CORE_RST;
                            cnt            <= RST_LOAD;
                            addr_q         <= bus.boot_addr;
                            bus.core_rstn  <= 1'b0;
                            bus.run_cycles <= '0;
                            bus.status     <= ST_NONE;
                            bus.busy       <= 1'b1;
                            bus.done       <= 1'b0;
                        end
                    end
                    CORE_RST: begin
                        if (cnt == '0) begin
                            state         <= CLK_ON;
                            cnt           <= SETTLE_LOAD;
                            bus.core_rstn <= 1'b1;
                            bus.cg_clk_en <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    CLK_ON: begin
                        if (cnt == '0) begin
                            state                   <= FETCH;
                            bus.first_fetch_trigger <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    FETCH: begin
                        state <= RUN;
                    end
                    RUN: begin
                        if (bus.core_halt) begin
                            state      <= DRAIN;
                            cnt        <= DRAIN_LOAD;
                            bus.status <= ST_HALT;
                        end else if (wd_expired) begin
                            state         <= STOP;
                            bus.cg_clk_en <= 1'b0;
                            bus.status    <= ST_TIMEOUT;
                        end
                    end
                    DRAIN: begin
                        if (cnt == '0) begin
                            state         <= STOP;
                            bus.cg_clk_en <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    STOP: begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    a_trig_pulse: assert property (@(posedge clk) disable iff (rst)
        bus.first_fetch_trigger |=> !bus.first_fetch_trigger);
    a_busy_done: assert property (@(posedge clk) disable iff (rst)
        !(bus.busy && bus.done));

endmodule
